spi_slave_phy: RTL and testbench
================================

# spi_slave_phy

SPI slave physical layer between the external SPI pins and the command state machine. Mode 0 (CPOL=0, CPHA=0), MSB first. It oversamples SCLK, CS_n and MOSI in the system clock domain, delivers each received byte as a one-cycle strobe, and shifts out one queued response byte per SPI byte. Its byte-level ports connect directly to the command state machine's `spi_data`/`valid`/`spi_data_out`/`spi_tx_valid`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `cs_n` and `mosi`; minimum 2.
- `IDLE_BYTE`, 8'h00: byte shifted out when no response is queued.
- `clk` in 1: system clock. The only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `cs_n` in 1: SPI chip select, active low, asynchronous.
- `mosi` in 1: SPI data in, asynchronous.
- `miso` out 1: SPI data out.
- `miso_oe` out 1: high while the frame is active. Drives the pad tristate.
- `rx_data` out 8: last received byte. Held until the next strobe.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data` in 8: response byte.
- `tx_valid` in 1: one-cycle strobe that queues `tx_data`.
- `frame_active` out 1: high while state is ACTIVE.
- `tx_underrun` out 1: one-cycle strobe when `IDLE_BYTE` is loaded in place of a queued byte during ACTIVE.

## Operation
- Synchronized signals: `sclk_s`, `cs_n_s`, `mosi_s`, each `SYNC_STAGES` flops.
- Edge detection compares each synchronized signal with a one-cycle-delayed copy. This gives `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise`.
- States:
  - WAIT_CS_HIGH (reset state): leave to IDLE when `cs_n_s`=1. This discards a frame already in progress when reset releases.
  - IDLE: on `cs_fall`, go to ACTIVE, clear `bit_cnt`, and perform a tx load.
  - ACTIVE: on `cs_rise`, go to IDLE. `cs_rise` has priority over any SCLK edge detected in the same cycle.
- Receive, on `sclk_rise` in ACTIVE:
  - `rx_shift <= {rx_shift[6:0], mosi_s}`; `bit_cnt` (3 bits) increments and wraps.
  - When `bit_cnt`==7, also set `rx_data <= {rx_shift[6:0], mosi_s}`, pulse `rx_valid` next cycle, and set `byte_done`.
- A partial byte (fewer than 8 rises) at `cs_rise` is dropped: no `rx_valid`, `bit_cnt` cleared.
- Transmit:
  - `tx_shift` bit 7 drives `miso`.
  - On `sclk_fall` in ACTIVE with `byte_done` set: perform a tx load and clear `byte_done`.
  - On any other `sclk_fall` in ACTIVE: `tx_shift <= {tx_shift[6:0], 1'b0}`.
- Tx load:
  - If `pending` is set, or `tx_valid` is high in the same cycle: `tx_shift <=` that byte, and `pending` clears. A same-cycle `tx_valid` bypasses the pending register.
  - Otherwise: `tx_shift <= IDLE_BYTE`. Pulse `tx_underrun` only if the load came from an `sclk_fall` (not `cs_fall`).
- Pending register:
  - `tx_valid` outside a load cycle sets `pending` and stores `tx_data`.
  - A second `tx_valid` before the next load overwrites the stored byte (last wins).
  - `cs_rise` clears `pending`.
- A response queued during byte N (after its `rx_valid`) is transmitted as byte N+1.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `frame_active`=0, `tx_underrun`=0, `pending`=0, `bit_cnt`=0, state=WAIT_CS_HIGH.
- All outputs are registered.
- `rx_valid` latency: pin rise of the 8th SCLK to `rx_valid` high is `SYNC_STAGES`+2 clk cycles.
- `miso` latency: SCLK falling pin edge to `miso` update is `SYNC_STAGES`+2 clk cycles.
- Supported SCLK: high and low phases each ≥ `SYNC_STAGES`+4 clk cycles (f_clk ≥ 12·f_sclk with defaults). This guarantees that `tx_valid` issued one cycle after `rx_valid` is queued before the following `sclk_fall`.
- Setup between `cs_n` pin fall and the first SCLK rise: ≥ `SYNC_STAGES`+3 clk cycles.
- `miso_oe` follows `frame_active`.

## Structure
- Package `spi_pkg`:
  - state enum `spi_phy_state_t` {WAIT_CS_HIGH, IDLE, ACTIVE};
  - `SPI_IDLE_BYTE` constant;
  - the command opcodes (`WRITE_8BIT_REG` 8'h87, `RX_DATA` 8'h88, `RX_SD_DATA` 8'h89, `READ_SD_FIFO` 8'h8A), moved here so both SPI blocks share them.
- Sub-module `sync_ff` (parameter `STAGES`, 1-bit), instantiated three times.
- Everything else in one always block plus output assigns.

## Test plan
- Reset mid-frame: `cs_n` low, 3 bits clocked, `rst` pulsed, then 8 more bits → no `rx_valid` until `cs_n` goes high then low. After that, byte 8'h87 → `rx_valid` once, `rx_data`=8'h87.
- Two-byte frame 8'h8A, 8'hFF, with `tx_valid`/`tx_data`=8'h5C asserted 1 cycle after the first `rx_valid` → `miso` carries 8'h00 in byte 1 and 8'h5C in byte 2. `tx_underrun` stays 0.
- Three-byte frame with a response queued only after byte 1 → byte 3 carries 8'h00 and `tx_underrun` pulses once.
- Partial byte: 5 SCLK cycles, then `cs_n` high → no `rx_valid`. The next frame's byte 8'hA5 → `rx_data`=8'hA5.
- Simultaneous events:
  - `tx_valid` (8'h3C) in the same cycle as the load-causing `sclk_fall` → byte carries 8'h3C.
  - Two `tx_valid` (8'h11 then 8'h22) before a load → 8'h22 transmitted.
- Minimum-speed SCLK (half period `SYNC_STAGES`+4 clk), 16 random bytes with echo responses → every `rx_data` matches and `miso` stream equals the input stream delayed by one byte.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and constants for the PHY and the command state machine
package spi_pkg;

   typedef enum logic [1:0] {
      WAIT_CS_HIGH,
      IDLE,
      ACTIVE
   } spi_phy_state_t;

   localparam logic [7:0] SPI_IDLE_BYTE  = 8'h00;

   localparam logic [7:0] WRITE_8BIT_REG = 8'h87;
   localparam logic [7:0] RX_DATA        = 8'h88;
   localparam logic [7:0] RX_SD_DATA     = 8'h89;
   localparam logic [7:0] READ_SD_FIFO   = 8'h8A;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing a 1-bit asynchronous input into clk
//   clk, rst : system clock, synchronous active-high reset (chain clears to 0)
//   d_i      : asynchronous input
//   q_o      : synchronized output
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_phy.sv
// spi_slave_phy: mode-0 MSB-first SPI slave, oversampled in the clk domain
//   sclk, cs_n, mosi    : asynchronous SPI pins
//   miso, miso_oe       : SPI data out and its pad enable
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   tx_data, tx_valid   : response byte and its one-cycle queue strobe
//   frame_active        : chip select frame in progress
//   tx_underrun         : idle byte sent because no response was queued
module spi_slave_phy
   import spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       frame_active,
   output logic       tx_underrun
);

   logic           sclk_s, cs_n_s, mosi_s;
   logic           sclk_dly_q, cs_n_dly_q;
   logic           sclk_rise, sclk_fall, cs_fall, cs_rise;
   spi_phy_state_t state_q;
   logic [2:0]     bit_cnt_q;
   logic [6:0]     rx_shift_q;
   logic [7:0]     rx_data_q;
   logic           rx_hit_q, rx_valid_q;
   logic [7:0]     tx_shift_q, pend_data_q;
   logic           pending_q, byte_done_q;
   logic           miso_q, frame_q, underrun_q;
   logic           load_cs, load_sclk, load, have_byte;
   logic [7:0]     load_byte;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sclk_sync (.clk, .rst, .d_i(sclk), .q_o(sclk_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_cs_sync   (.clk, .rst, .d_i(cs_n), .q_o(cs_n_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_mosi_sync (.clk, .rst, .d_i(mosi), .q_o(mosi_s));

   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign cs_fall   = ~cs_n_s & cs_n_dly_q;
   assign cs_rise   = cs_n_s & ~cs_n_dly_q;

   // A load happens at frame start and on the first falling SCLK after a full byte;
   // a chip-select release in the same cycle wins over the SCLK edge.
   assign load_cs   = (state_q == IDLE) && cs_fall;
   assign load_sclk = (state_q == ACTIVE) && !cs_rise && sclk_fall && byte_done_q;
   assign load      = load_cs | load_sclk;
   assign have_byte = pending_q | tx_valid;
   assign load_byte = tx_valid ? tx_data : pending_q ? pend_data_q : IDLE_BYTE;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_dly_q  <= 1'b0;
         cs_n_dly_q  <= 1'b0;
         state_q     <= WAIT_CS_HIGH;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_hit_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         tx_shift_q  <= '0;
         pend_data_q <= '0;
         pending_q   <= 1'b0;
         byte_done_q <= 1'b0;
         miso_q      <= 1'b0;
         frame_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sclk_dly_q <= sclk_s;
         cs_n_dly_q <= cs_n_s;
         rx_hit_q   <= 1'b0;
         rx_valid_q <= rx_hit_q;
         miso_q     <= tx_shift_q[7];
         underrun_q <= 1'b0;
         if (tx_valid && !load) begin
            pending_q   <= 1'b1;
            pend_data_q <= tx_data;
         end
         if (load) begin
            tx_shift_q <= load_byte;
            pending_q  <= 1'b0;
            underrun_q <= load_sclk && !have_byte;
         end
         case (state_q)
            WAIT_CS_HIGH: begin
               if (cs_n_s) state_q <= IDLE;
            end
            IDLE: begin
               if (cs_fall) begin
                  state_q     <= ACTIVE;
                  frame_q     <= 1'b1;
                  bit_cnt_q   <= '0;
                  byte_done_q <= 1'b0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state_q     <= IDLE;
                  frame_q     <= 1'b0;
                  bit_cnt_q   <= '0;
                  byte_done_q <= 1'b0;
                  pending_q   <= 1'b0;
               end else begin
                  if (sclk_rise) begin
                     rx_shift_q <= {rx_shift_q[5:0], mosi_s};
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        rx_data_q   <= {rx_shift_q, mosi_s};
                        rx_hit_q    <= 1'b1;
                        byte_done_q <= 1'b1;
                     end
                  end
                  if (sclk_fall) begin
                     if (byte_done_q) byte_done_q <= 1'b0;
                     else             tx_shift_q  <= {tx_shift_q[6:0], 1'b0};
                  end
               end
            end
            default: begin
               state_q <= WAIT_CS_HIGH;
               frame_q <= 1'b0;
            end
         endcase
      end
   end

   assign miso         = miso_q;
   assign miso_oe      = frame_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign frame_active = frame_q;
   assign tx_underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave_phy.sv
// tb_spi_slave_phy: directed mode-0 SPI master driving spi_slave_phy
module tb_spi_slave_phy;

   localparam int S = 2;
   localparam int H = S + 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, miso_oe, rx_valid, frame_active, tx_underrun;
   logic [7:0] rx_data;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tv_main = 1'b0;
   logic       tv_resp = 1'b0;
   logic [7:0] td_main = 8'h00;
   logic [7:0] td_resp = 8'h00;
   logic [7:0] resp_byte = 8'h00;
   logic [7:0] last_rx = 8'h00;
   bit         resp_echo = 1'b0;
   int         resp_target = 0;
   int         resp_done = 0;
   int         rv_cnt = 0;
   int         ur_cnt = 0;
   int         n_chk = 0;
   int         n_err = 0;

   assign tx_valid = tv_main | tv_resp;
   assign tx_data  = tv_resp ? td_resp : td_main;

   always #5 clk = ~clk;

   spi_slave_phy #(.SYNC_STAGES(S), .IDLE_BYTE(8'h00)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .frame_active(frame_active),
      .tx_underrun(tx_underrun)
   );

   always @(negedge clk) begin
      if (rx_valid) begin
         rv_cnt++;
         last_rx = rx_data;
      end
      if (tx_underrun) ur_cnt++;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid && resp_done < resp_target) begin
            td_resp = resp_echo ? rx_data : resp_byte;
            @(posedge clk); #1 tv_resp = 1'b1;
            @(posedge clk); #1 tv_resp = 1'b0;
            resp_done++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] mo, input int nb, input bit last, input bit inj,
                       input logic [7:0] inj_d, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         mosi = mo[i];
         tick(H);
         mi[i] = miso;
         sclk = 1'b1;
         tick(H);
         sclk = 1'b0;
         if (i == 8 - nb) begin
            if (last) cs_n = 1'b1;
            if (inj) begin
               tick(S);
               td_main = inj_d;
               tv_main = 1'b1;
               tick(1);
               tv_main = 1'b0;
            end
         end
      end
   endtask

   initial begin
      logic [7:0] m0, m1, m2;
      logic [7:0] din [16];
      logic [7:0] dout [16];
      int rv0, ur0;
      tick(3);
      chk("rst_miso", 32'(miso), 0);
      chk("rst_miso_oe", 32'(miso_oe), 0);
      chk("rst_rx_data", 32'(rx_data), 0);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_frame_active", 32'(frame_active), 0);
      chk("rst_tx_underrun", 32'(tx_underrun), 0);
      rst = 1'b0;
      tick(H);
      cs_n = 1'b0;
      tick(H);
      xfer(8'hE0, 3, 1'b0, 1'b0, 8'h00, m0);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      rv0 = rv_cnt;
      xfer(8'hFF, 8, 1'b0, 1'b0, 8'h00, m0);
      chk("midrst_no_rx", 32'(rv_cnt - rv0), 0);
      chk("midrst_frame", 32'(frame_active), 0);
      cs_n = 1'b1;
      tick(H);
      cs_n = 1'b0;
      tick(H);
      chk("frame_active_hi", 32'(frame_active), 1);
      chk("miso_oe_hi", 32'(miso_oe), 1);
      xfer(8'h87, 8, 1'b1, 1'b0, 8'h00, m0);
      tick(H);
      chk("op87_count", 32'(rv_cnt - rv0), 1);
      chk("op87_data", 32'(rx_data), 'h87);
      chk("frame_active_lo", 32'(frame_active), 0);

      rv0 = rv_cnt; ur0 = ur_cnt;
      resp_byte = 8'h5C; resp_target++;
      cs_n = 1'b0;
      tick(H);
      xfer(8'h8A, 8, 1'b0, 1'b0, 8'h00, m0);
      chk("two_rx1", 32'(last_rx), 'h8A);
      xfer(8'hFF, 8, 1'b1, 1'b0, 8'h00, m1);
      tick(H);
      chk("two_miso1", 32'(m0), 'h00);
      chk("two_miso2", 32'(m1), 'h5C);
      chk("two_rx2", 32'(last_rx), 'hFF);
      chk("two_count", 32'(rv_cnt - rv0), 2);
      chk("two_underrun", 32'(ur_cnt - ur0), 0);

      ur0 = ur_cnt;
      resp_byte = 8'h42; resp_target++;
      cs_n = 1'b0;
      tick(H);
      xfer(8'h01, 8, 1'b0, 1'b0, 8'h00, m0);
      xfer(8'h02, 8, 1'b0, 1'b0, 8'h00, m1);
      xfer(8'h03, 8, 1'b1, 1'b0, 8'h00, m2);
      tick(H);
      chk("three_miso1", 32'(m0), 'h00);
      chk("three_miso2", 32'(m1), 'h42);
      chk("three_miso3", 32'(m2), 'h00);
      chk("three_underrun", 32'(ur_cnt - ur0), 1);

      rv0 = rv_cnt;
      cs_n = 1'b0;
      tick(H);
      xfer(8'hF8, 5, 1'b1, 1'b0, 8'h00, m0);
      tick(H);
      chk("partial_no_rx", 32'(rv_cnt - rv0), 0);
      chk("partial_hold", 32'(rx_data), 'h03);
      cs_n = 1'b0;
      tick(H);
      xfer(8'hA5, 8, 1'b1, 1'b0, 8'h00, m0);
      tick(H);
      chk("after_partial_count", 32'(rv_cnt - rv0), 1);
      chk("after_partial_data", 32'(rx_data), 'hA5);

      ur0 = ur_cnt;
      cs_n = 1'b0;
      tick(H);
      xfer(8'h10, 8, 1'b0, 1'b1, 8'h3C, m0);
      xfer(8'h20, 8, 1'b0, 1'b0, 8'h00, m1);
      xfer(8'h30, 8, 1'b1, 1'b0, 8'h00, m2);
      tick(H);
      chk("bypass_miso1", 32'(m0), 'h00);
      chk("bypass_miso2", 32'(m1), 'h3C);
      chk("bypass_miso3", 32'(m2), 'h00);
      chk("bypass_underrun", 32'(ur_cnt - ur0), 1);

      td_main = 8'h11; tv_main = 1'b1;
      tick(1);
      tv_main = 1'b0;
      tick(2);
      td_main = 8'h22; tv_main = 1'b1;
      tick(1);
      tv_main = 1'b0;
      cs_n = 1'b0;
      tick(H);
      xfer(8'h55, 8, 1'b1, 1'b0, 8'h00, m0);
      tick(H);
      chk("last_wins", 32'(m0), 'h22);

      rv0 = rv_cnt; ur0 = ur_cnt;
      resp_echo = 1'b1;
      resp_target += 16;
      cs_n = 1'b0;
      tick(H);
      for (int k = 0; k < 16; k++) begin
         din[k] = 8'($urandom_range(0, 255));
         xfer(din[k], 8, k == 15, 1'b0, 8'h00, dout[k]);
         chk("echo_rx", 32'(last_rx), 32'(din[k]));
         chk("echo_miso", 32'(dout[k]), k == 0 ? 0 : 32'(din[k-1]));
      end
      tick(H);
      chk("echo_count", 32'(rv_cnt - rv0), 16);
      chk("echo_underrun", 32'(ur_cnt - ur0), 0);
      resp_echo = 1'b0;
      cs_n = 1'b0;
      tick(H);
      xfer(8'h66, 8, 1'b1, 1'b0, 8'h00, m0);
      tick(H);
      chk("pending_cleared", 32'(m0), 'h00);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
